// File: rtl/fft_pkg.sv
// Shared constants and FSM encoding for the Q15 complex datapath blocks.
package fft_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int Q_FRAC        = 15;
    localparam int Q15_MAX       = 32767;
    localparam int Q15_MIN       = -32768;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/complex_divider_if.sv
// Request/response bundle of the complex divider.
interface complex_divider_if
    import fft_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a_real;
    logic [WIDTH-1:0] a_imag;
    logic [WIDTH-1:0] b_real;
    logic [WIDTH-1:0] b_imag;
    logic             busy;
    logic [WIDTH-1:0] result_real;
    logic [WIDTH-1:0] result_imag;
    logic             valid;
    logic             div_by_zero;
    logic             saturated;

    modport master (
        output start, a_real, a_imag, b_real, b_imag,
        input  busy, result_real, result_imag, valid, div_by_zero, saturated
    );

    modport slave (
        input  start, a_real, a_imag, b_real, b_imag,
        output busy, result_real, result_imag, valid, div_by_zero, saturated
    );

endinterface

// File: rtl/cdiv_step.sv
// One restoring-division step: shift in a dividend bit, subtract den if it fits.
module cdiv_step #(
    parameter int RW = 35,
    parameter int DW = 33
) (
    input  logic [RW-1:0] rem,
    input  logic          num_bit,
    input  logic [DW-1:0] den,
    output logic [RW-1:0] rem_next,
    output logic          q_bit
);

    logic [RW:0] shifted;
    logic [RW:0] den_x;

    always_comb begin
        shifted  = {rem, num_bit};
        den_x    = (RW+1)'(den);
        q_bit    = (shifted >= den_x);
        rem_next = q_bit ? RW'(shifted - den_x) : RW'(shifted);
    end

endmodule

// File: rtl/complex_divider.sv
// Iterative Q15 complex divider q = a*conj(b)/|b|^2, one quotient bit per cycle.
// state | meaning:  IDLE wait start | PREP products/abs/den | DIV ITER steps | DONE sign+saturate
module complex_divider
    import fft_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int ITER  = WIDTH + 1
) (
    input logic              clk,
    input logic              rst,
    complex_divider_if.slave bus
);

    localparam int NW = 2 * WIDTH + 1;
    localparam int RW = 2 * WIDTH + 3;
    localparam int CW = $clog2(ITER);
    localparam logic [WIDTH-1:0] POS_RAIL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_RAIL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t state, state_next;
    logic capture, prep, step, done;
    logic [CW-1:0] cnt;

    logic signed [WIDTH-1:0] ar, ai, br, bi;
    logic signed [NW-1:0] arx, aix, brx, bix, num_re, num_im, den_s;
    logic [NW-1:0] abs_re_c, abs_im_c, den_c;
    logic [NW-1:0] abs_re, abs_im, den;
    logic neg_re, neg_im, nz_re, nz_im, ovf_re, ovf_im, dz;
    logic [RW-1:0] rem_re, rem_im, rem_re_in, rem_im_in, rem_re_nx, rem_im_nx;
    logic [ITER-1:0] q_re, q_im, lo_re, lo_im;
    logic qb_re, qb_im;
    logic [WIDTH:0] fin_re, fin_im;

    // Returns {clipped, value}. A zero divisor rails on the sign of the dividend.
    function automatic logic [WIDTH:0] finish(input logic [ITER-1:0] q, input logic neg,
                                              input logic nz, input logic ovf, input logic zero_div);
        logic [ITER-1:0]  nq;
        logic [WIDTH-1:0] val;
        logic             clip;
        nq   = -q;
        clip = 1'b0;
        if (zero_div) begin
            val = nz ? (neg ? NEG_RAIL : POS_RAIL) : {WIDTH{1'b0}};
        end else if (ovf) begin
            val  = neg ? NEG_RAIL : POS_RAIL;
            clip = 1'b1;
        end else if (!neg) begin
            clip = (q > ITER'(POS_RAIL));
            val  = clip ? POS_RAIL : q[WIDTH-1:0];
        end else begin
            clip = (q > ITER'(NEG_RAIL));
            val  = clip ? NEG_RAIL : nq[WIDTH-1:0];
        end
        return {clip, val};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = PREP;
            PREP:    state_next = DIV;
            DIV:     if (cnt == CW'(0)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        capture  = (state == IDLE) && bus.start;
        prep     = (state == PREP);
        step     = (state == DIV);
        done     = (state == DONE);
        bus.busy = (state != IDLE);
    end

    always_comb begin
        arx      = NW'(ar);
        aix      = NW'(ai);
        brx      = NW'(br);
        bix      = NW'(bi);
        num_re   = arx * brx + aix * bix;
        num_im   = aix * brx - arx * bix;
        den_s    = brx * brx + bix * bix;
        den_c    = den_s;
        abs_re_c = num_re[NW-1] ? NW'(-num_re) : NW'(num_re);
        abs_im_c = num_im[NW-1] ? NW'(-num_im) : NW'(num_im);
        // Dividend is |num| << (WIDTH-1): high part seeds the remainder, low ITER bits feed the steps.
        lo_re     = ITER'({abs_re, {(WIDTH-1){1'b0}}});
        lo_im     = ITER'({abs_im, {(WIDTH-1){1'b0}}});
        rem_re_in = (cnt == CW'(ITER-1)) ? RW'({abs_re, {(WIDTH-1){1'b0}}} >> ITER) : rem_re;
        rem_im_in = (cnt == CW'(ITER-1)) ? RW'({abs_im, {(WIDTH-1){1'b0}}} >> ITER) : rem_im;
        fin_re    = finish(q_re, neg_re, nz_re, ovf_re, dz);
        fin_im    = finish(q_im, neg_im, nz_im, ovf_im, dz);
    end

    cdiv_step #(.RW(RW), .DW(NW)) u_step_re (
        .rem(rem_re_in), .num_bit(lo_re[cnt]), .den(den), .rem_next(rem_re_nx), .q_bit(qb_re)
    );

    cdiv_step #(.RW(RW), .DW(NW)) u_step_im (
        .rem(rem_im_in), .num_bit(lo_im[cnt]), .den(den), .rem_next(rem_im_nx), .q_bit(qb_im)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar <= '0; ai <= '0; br <= '0; bi <= '0;
            abs_re <= '0; abs_im <= '0; den <= '0; dz <= 1'b0;
            neg_re <= 1'b0; neg_im <= 1'b0; nz_re <= 1'b0; nz_im <= 1'b0;
            ovf_re <= 1'b0; ovf_im <= 1'b0; cnt <= '0;
            rem_re <= '0; rem_im <= '0; q_re <= '0; q_im <= '0;
            bus.result_real <= '0; bus.result_imag <= '0;
            bus.valid <= 1'b0; bus.div_by_zero <= 1'b0; bus.saturated <= 1'b0;
        end else begin
            if (capture) begin
                ar <= bus.a_real; ai <= bus.a_imag;
                br <= bus.b_real; bi <= bus.b_imag;
            end
            if (prep) begin
                abs_re <= abs_re_c;
                abs_im <= abs_im_c;
                den    <= den_c;
                dz     <= (den_c == '0);
                neg_re <= (den_c == '0) ? ar[WIDTH-1] : num_re[NW-1];
                neg_im <= (den_c == '0) ? ai[WIDTH-1] : num_im[NW-1];
                nz_re  <= (den_c == '0) ? (ar != '0) : (num_re != '0);
                nz_im  <= (den_c == '0) ? (ai != '0) : (num_im != '0);
                ovf_re <= ({2'b00, abs_re_c} >= {den_c, 2'b00});
                ovf_im <= ({2'b00, abs_im_c} >= {den_c, 2'b00});
                cnt    <= CW'(ITER-1);
            end
            if (step) begin
                rem_re <= rem_re_nx;
                rem_im <= rem_im_nx;
                q_re   <= {q_re[ITER-2:0], qb_re};
                q_im   <= {q_im[ITER-2:0], qb_im};
                cnt    <= cnt - CW'(1);
            end
            if (done) begin
                bus.result_real <= fin_re[WIDTH-1:0];
                bus.result_imag <= fin_im[WIDTH-1:0];
                bus.saturated   <= fin_re[WIDTH] | fin_im[WIDTH];
                bus.div_by_zero <= dz;
            end
            bus.valid <= done;
        end
    end

endmodule

// File: tb/tb_complex_divider.sv
// Self-checking bench: arithmetic reference model plus per-cycle output compare.
module tb_complex_divider;

    localparam int LAT = 19;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    complex_divider_if #(.WIDTH(16)) bus ();

    complex_divider #(.WIDTH(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    typedef struct {
        int e0;
        int qr;
        int qi;
        bit dz;
        bit sat;
    } exp_t;

    exp_t pq[$];
    exp_t last;
    exp_t nw;
    bit   ev, eb;

    task automatic chk(input string name, input longint act, input longint req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
    endtask

    function automatic void comp(input longint n, input longint d, output int q, output bit clip);
        longint mag, v;
        mag  = ((n < 0) ? -n : n) * 32768 / d;
        v    = (n < 0) ? -mag : mag;
        clip = 1'b0;
        if (v > 32767) begin v = 32767; clip = 1'b1; end
        else if (v < -32768) begin v = -32768; clip = 1'b1; end
        q = int'(v);
    endfunction

    function automatic void model(input int ar, input int ai, input int br, input int bi,
                                  output int qr, output int qi, output bit dz, output bit sat);
        longint nr, ni, d;
        bit cr, ci;
        nr = longint'(ar) * br + longint'(ai) * bi;
        ni = longint'(ai) * br - longint'(ar) * bi;
        d  = longint'(br) * br + longint'(bi) * bi;
        if (d == 0) begin
            dz  = 1'b1;
            sat = 1'b0;
            qr  = (ar > 0) ? 32767 : (ar < 0) ? -32768 : 0;
            qi  = (ai > 0) ? 32767 : (ai < 0) ? -32768 : 0;
        end else begin
            dz = 1'b0;
            comp(nr, d, qr, cr);
            comp(ni, d, qi, ci);
            sat = cr | ci;
        end
    endfunction

    task automatic pin(input int ar, input int ai, input int br, input int bi,
                       input int eqr, input int eqi, input bit edz, input bit esat);
        int qr, qi;
        bit dz, sat;
        model(ar, ai, br, bi, qr, qi, dz, sat);
        chk("model_re", qr, eqr);
        chk("model_im", qi, eqi);
        chk("model_dz", dz, edz);
        chk("model_sat", sat, esat);
    endtask

    function automatic int rnd16();
        case ($urandom_range(0, 4))
            0:       return int'($signed(16'($urandom)));
            1:       return int'($urandom_range(0, 600)) - 300;
            2:       return 0;
            3:       return ($urandom_range(0, 1) == 1) ? 32767 : -32768;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: checks every output on every cycle against the model-driven expectation.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_valid", bus.valid, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_res_re", $signed(bus.result_real), 0);
            chk("rst_res_im", $signed(bus.result_imag), 0);
            chk("rst_dz", bus.div_by_zero, 0);
            chk("rst_sat", bus.saturated, 0);
            pq.delete();
            last = '{default: 0};
        end else begin
            ev = (pq.size() > 0) && (cyc == pq[0].e0 + LAT);
            eb = (pq.size() > 0) && (cyc >= pq[0].e0) && (cyc < pq[0].e0 + LAT);
            chk("valid", bus.valid, ev);
            chk("busy", bus.busy, eb);
            if (ev) last = pq.pop_front();
            chk("res_re", $signed(bus.result_real), last.qr);
            chk("res_im", $signed(bus.result_imag), last.qi);
            chk("div_by_zero", bus.div_by_zero, last.dz);
            chk("saturated", bus.saturated, last.sat);
            if (bus.start && !bus.busy) begin
                nw.e0 = cyc + 1;
                model(int'($signed(bus.a_real)), int'($signed(bus.a_imag)),
                      int'($signed(bus.b_real)), int'($signed(bus.b_imag)),
                      nw.qr, nw.qi, nw.dz, nw.sat);
                pq.push_back(nw);
            end
        end
    end

    task automatic issue(input int ar, input int ai, input int br, input int bi);
        int n = 0;
        while (bus.busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_before_start", bus.busy, 0);
        bus.start  = 1'b1;
        bus.a_real = 16'(ar);
        bus.a_imag = 16'(ai);
        bus.b_real = 16'(br);
        bus.b_imag = 16'(bi);
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.a_real = 16'($urandom);
        bus.a_imag = 16'($urandom);
        bus.b_real = 16'($urandom);
        bus.b_imag = 16'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (pq.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", pq.size(), 0);
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.a_real = '0;
        bus.a_imag = '0;
        bus.b_real = '0;
        bus.b_imag = '0;

        pin(8192, 0, 16384, 0, 16384, 0, 0, 0);
        pin(-8192, 0, 0, 16384, 0, 16384, 0, 0);
        pin(0, 8192, 0, 16384, 16384, 0, 0, 0);
        pin(1, 0, 3, 0, 10922, 0, 0, 0);
        pin(-1, 0, 3, 0, -10922, 0, 0, 0);
        pin(16384, 0, 8192, 0, 32767, 0, 0, 1);
        pin(-16384, 0, 8192, 0, -32768, 0, 0, 1);
        pin(100, -100, 0, 0, 32767, -32768, 1, 0);
        pin(0, 0, 0, 0, 0, 0, 1, 0);

        gap(3);
        rst = 1'b0;
        gap(2);

        issue(8192, 0, 16384, 0);
        wait_done();
        gap(3);

        issue(-8192, 0, 0, 16384);
        issue(0, 8192, 0, 16384);
        wait_done();

        issue(1, 0, 3, 0);
        issue(-1, 0, 3, 0);
        issue(16384, 0, 8192, 0);
        issue(-16384, 0, 8192, 0);
        issue(100, -100, 0, 0);
        issue(0, 0, 0, 0);
        wait_done();
        gap(2);

        // Abort mid-operation: reset at E10, nothing may follow.
        issue(12345, -2345, 20000, 3000);
        gap(10);
        rst = 1'b1;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_valid", bus.valid, 0);
        chk("abort_res_re", $signed(bus.result_real), 0);
        chk("abort_res_im", $signed(bus.result_imag), 0);
        chk("abort_sat", bus.saturated, 0);
        gap(2);
        rst = 1'b0;
        gap(30);

        // Start while busy is ignored.
        issue(1000, 2000, 3000, -4000);
        gap(4);
        bus.start  = 1'b1;
        bus.a_real = 16'(-7000);
        bus.a_imag = 16'(500);
        bus.b_real = 16'(9);
        bus.b_imag = 16'(-3);
        gap(1);
        bus.start = 1'b0;
        wait_done();

        for (int i = 0; i < 150; i++) begin
            issue(rnd16(), rnd16(), rnd16(), rnd16());
            if ($urandom_range(0, 3) == 0) begin
                gap($urandom_range(1, 15));
                bus.start  = 1'b1;
                bus.a_real = 16'($urandom);
                bus.b_real = 16'($urandom);
                gap(1);
                bus.start = 1'b0;
            end
            if ($urandom_range(0, 2) == 0) begin
                wait_done();
                gap($urandom_range(0, 3));
            end
        end
        wait_done();
        gap(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/complex_divider.md
Name: complex_divider

Overview:
Iterative Q15 complex divider computing q = a / b = (a·conj(b)) / |b|².
- Inverse companion to the FFT datapath's Q15 complex multiplier; used for IFFT normalisation and channel equalisation.
- Accepts one operand pair per start pulse and returns a saturated Q15 result with a one-cycle valid pulse after a fixed latency.
- Real and imaginary quotients share one denominator and are divided in parallel, one quotient bit per cycle.

Parameters:
WIDTH, 16, operand/result width, signed Q(WIDTH-1) fixed point
ITER, WIDTH+1, restoring-division iterations (quotient magnitude bits)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  request; sampled only when busy=0
a_real  input  WIDTH  dividend real, signed Q15
a_imag  input  WIDTH  dividend imag, signed Q15
b_real  input  WIDTH  divisor real, signed Q15
b_imag  input  WIDTH  divisor imag, signed Q15
busy  output  1  operation in flight
result_real  output  WIDTH  quotient real, signed Q15
result_imag  output  WIDTH  quotient imag, signed Q15
valid  output  1  one-cycle pulse, results updated
div_by_zero  output  1  qualified by valid: b was (0,0)
saturated  output  1  qualified by valid: either component clipped

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset state:
  - All outputs are 0 and state is IDLE.
  - Reset asserted mid-operation aborts the operation: no valid pulse follows and the operands are discarded.
- Handshake:
  - start is accepted at edge E0 only if busy=0. Operands are captured at E0 and need not be held afterwards.
  - start while busy=1 is ignored. No queueing.
- States:
  - IDLE: go to PREP when start is accepted.
  - PREP: 1 cycle. Register the following values:
    - num_r = ar·br + ai·bi, signed 2W+1
    - num_i = ai·br − ar·bi, signed 2W+1
    - den = br² + bi², unsigned 2W+1
    - the signs of num_r and num_i
    - |num_r| and |num_i|
    - the zero-divisor flag
    - the overflow pre-check: |num| ≥ 4·den, meaning the quotient is ≥ 2^ITER
  - DIV: exactly ITER cycles. Each cycle is one restoring step per component on |num|·2^(W−1) / den. Remainder is 2W+3 bits. Real and imag steps run in parallel.
  - DONE: 1 cycle. Apply sign, saturate and register results; valid=1 for this cycle; return to IDLE.
- Latency:
  - valid is high after edge E0+ITER+2 (E19 for WIDTH=16), for exactly one cycle.
  - busy is high from E0 until the edge that raises valid; busy=0 in the valid cycle.
  - start in the valid cycle is accepted, giving back-to-back throughput of one result per ITER+3 cycles.
- Arithmetic:
  - Quotient magnitude is truncated (toward zero), then negated if the numerator sign is negative.
  - Saturation, per component:
    - positive above 32767 clips to 32767
    - negative below −32768 clips to −32768
    - a pre-check overflow clips to the rail of that component's sign
    - saturated=1 if either component clips
- Divide by zero (b=(0,0)):
  - Latency is unchanged.
  - Each component is 32767 if num>0, −32768 if num<0, and 0 if num=0.
  - div_by_zero=1; saturated=0.
- Hold: results, div_by_zero and saturated hold their values until the next DONE or reset.

Decomposition:
- Shared package fft_pkg:
  - WIDTH default
  - Q_FRAC=15
  - Q15_MAX=32767, Q15_MIN=−32768
  - state encoding: IDLE, PREP, DIV, DONE
- One sub-module, cdiv_step: a combinational single restoring-division step.
  - Inputs: remainder, next numerator bit, den.
  - Outputs: new remainder and quotient bit.
  - Instantiated twice (real and imag).
- The iteration counter and FSM live in complex_divider.

Test Plan:
1. a=(8192,0), b=(16384,0), start pulse → valid exactly at E19, result=(16384,0), flags 0, busy high E0..E18.
2. a=(−8192,0), b=(0,16384) → (0,16384). Then a=(0,8192), b=(0,16384) issued in the valid cycle → accepted, second valid 19 edges later, result (16384,0).
3. a=(1,0), b=(3,0) → (10922,0). Then a=(−1,0), b=(3,0) → (−10922,0), confirming truncation toward zero.
4. a=(16384,0), b=(8192,0) → (32767,0), saturated=1. Then a=(−16384,0), b=(8192,0) → (−32768,0), saturated=1.
5. a=(100,−100), b=(0,0) → (32767,−32768), div_by_zero=1, saturated=0, valid at E19. Also a=(0,0), b=(0,0) → (0,0), div_by_zero=1.
6. Two further cases, checked separately:
   - Start, assert rst at E10 → all outputs 0 immediately, no valid pulse ever.
   - Start at E0, second start at E5 with different operands → ignored; only the E0 operation's result appears.
